// File: rtl/issue_ctrl_pkg.sv
// Shared types and defaults for the dual-issue scheduler and its scoreboard.
package issue_ctrl_pkg;

  localparam int REG_ADDR_W          = 5;
  localparam int NUM_REGS            = 32;
  localparam int IC_ALU_LAT_DEF      = 1;
  localparam int IC_LOAD_LAT_DEF     = 2;
  localparam int IC_FLUSH_CYCLES_DEF = 1;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IC_ISSUE = 2'd0,
    IC_FLUSH = 2'd1,
    IC_MWAIT = 2'd2
  } ic_state_e;

  // True when an instruction actually reads register rd through either source.
  function automatic logic reads_reg(input logic use1, input reg_addr_t rs1,
                                     input logic use2, input reg_addr_t rs2,
                                     input reg_addr_t rd);
    return (use1 && (rs1 == rd)) || (use2 && (rs2 == rd));
  endfunction

endpackage

// File: rtl/issue_scoreboard.sv
// Per-register countdown scoreboard: a nonzero count means the result is not yet
// readable by a newly issued instruction. x0 never becomes pending.
module issue_scoreboard
  import issue_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            set0_en_i,
  input  reg_addr_t       set0_addr_i,
  input  logic [1:0]      set0_val_i,
  input  logic            set1_en_i,
  input  reg_addr_t       set1_addr_i,
  input  logic [1:0]      set1_val_i,
  input  logic            freeze_i,
  input  reg_addr_t [3:0] q_addr_i,
  output logic [3:0]      q_busy_o
);

  logic [1:0] cnt_q [NUM_REGS];
  logic [1:0] cnt_d [NUM_REGS];

  // A new issue to a register overrides its decrement in the same cycle.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = cnt_q[r];
      if (!freeze_i && (cnt_q[r] != 2'd0)) cnt_d[r] = cnt_q[r] - 2'd1;
      if (set0_en_i && (set0_addr_i == reg_addr_t'(r))) cnt_d[r] = set0_val_i;
      if (set1_en_i && (set1_addr_i == reg_addr_t'(r))) cnt_d[r] = set1_val_i;
    end
    cnt_d[0] = 2'd0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= 2'd0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  always_comb begin
    for (int q = 0; q < 4; q++) q_busy_o[q] = (cnt_q[q_addr_i[q]] != 2'd0);
  end

endmodule

// File: rtl/issue_ctrl.sv
// Dual-issue scheduler: picks up to two buffered instructions per cycle, steers them
// to FAB (ALU+branch) / FAM (ALU+memory), and sequences redirect flush and memory stall.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int ALU_LAT      = IC_ALU_LAT_DEF,
  parameter int LOAD_LAT     = IC_LOAD_LAT_DEF,
  parameter int FLUSH_CYCLES = IC_FLUSH_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] ib_valid,
  input  logic [1:0] ib_is_br,
  input  logic [1:0] ib_is_mem,
  input  logic [1:0] ib_is_load,
  input  logic [9:0] ib_rs1,
  input  logic [9:0] ib_rs2,
  input  logic [1:0] ib_rs1_use,
  input  logic [1:0] ib_rs2_use,
  input  logic [9:0] ib_rd,
  input  logic [1:0] ib_rd_we,
  output logic [1:0] ib_consume,
  output logic       ib_flush,
  output logic       fab_issue,
  output logic       fab_slot,
  output logic       fam_issue,
  output logic       fam_slot,
  output logic       fab_num,
  output logic       fam_num,
  output logic       de_ex_stop,
  output logic       de_ex_flush,
  input  logic       br_taken,
  input  logic       mem_wait
);

  localparam logic [1:0] ALU_VAL   = 2'(ALU_LAT);
  localparam logic [1:0] LOAD_VAL  = 2'(LOAD_LAT);
  localparam logic [1:0] FLUSH_VAL = 2'(FLUSH_CYCLES);

  ic_state_e  state_q, state_d;
  logic [1:0] flush_cnt_q, flush_cnt_d;

  reg_addr_t rs1_0, rs2_0, rd_0, rs1_1, rs2_1, rd_1;
  assign rs1_0 = ib_rs1[4:0];
  assign rs1_1 = ib_rs1[9:5];
  assign rs2_0 = ib_rs2[4:0];
  assign rs2_1 = ib_rs2[9:5];
  assign rd_0  = ib_rd[4:0];
  assign rd_1  = ib_rd[9:5];

  logic [3:0] src_busy;
  logic       s0_blocked, s1_blocked, s0_wr, s1_wr;
  logic       issue_en, s0_go, s1_go, raw_pair, waw_pair;

  issue_scoreboard u_sb (
    .clk         (clk),
    .rst         (rst),
    .set0_en_i   (s0_go && s0_wr),
    .set0_addr_i (rd_0),
    .set0_val_i  (ib_is_load[0] ? LOAD_VAL : ALU_VAL),
    .set1_en_i   (s1_go && s1_wr),
    .set1_addr_i (rd_1),
    .set1_val_i  (ib_is_load[1] ? LOAD_VAL : ALU_VAL),
    .freeze_i    (mem_wait),
    .q_addr_i    ({rs2_1, rs1_1, rs2_0, rs1_0}),
    .q_busy_o    (src_busy)
  );

  assign s0_blocked = (ib_rs1_use[0] && src_busy[0]) || (ib_rs2_use[0] && src_busy[1]);
  assign s1_blocked = (ib_rs1_use[1] && src_busy[2]) || (ib_rs2_use[1] && src_busy[3]);
  assign s0_wr      = ib_rd_we[0] && (rd_0 != '0);
  assign s1_wr      = ib_rd_we[1] && (rd_1 != '0);

  // MWAIT may issue on the cycle mem_wait drops; br_taken only matters in ISSUE.
  assign issue_en = rst && !mem_wait &&
                    (((state_q == IC_ISSUE) && !br_taken) || (state_q == IC_MWAIT));

  assign raw_pair = s0_wr && reads_reg(ib_rs1_use[1], rs1_1, ib_rs2_use[1], rs2_1, rd_0);
  assign waw_pair = (&ib_rd_we) && (rd_0 == rd_1);

  assign s0_go = issue_en && ib_valid[0] && !s0_blocked;
  assign s1_go = s0_go && ib_valid[1] && !ib_is_br[0] && !(&ib_is_mem) && !(&ib_is_br) &&
                 !raw_pair && !waw_pair && !s1_blocked;

  // In a pair, slot 1 takes FAB if it is the branch or if slot 0 is the memory op.
  always_comb begin
    fab_issue = 1'b0;
    fab_slot  = 1'b0;
    fam_issue = 1'b0;
    fam_slot  = 1'b0;
    if (s1_go) begin
      fab_issue = 1'b1;
      fam_issue = 1'b1;
      if (ib_is_br[1] || ib_is_mem[0]) begin
        fab_slot = 1'b1;
        fam_slot = 1'b0;
      end else begin
        fab_slot = 1'b0;
        fam_slot = 1'b1;
      end
    end else if (s0_go) begin
      if (ib_is_mem[0] && !ib_is_br[0]) fam_issue = 1'b1;
      else                              fab_issue = 1'b1;
    end
  end

  assign fab_num    = fab_slot;
  assign fam_num    = fam_slot;
  assign ib_consume = s1_go ? 2'd2 : (s0_go ? 2'd1 : 2'd0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IC_ISSUE;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    ib_flush    = 1'b0;
    de_ex_flush = 1'b0;
    de_ex_stop  = 1'b0;
    case (state_q)
      IC_ISSUE: begin
        if (br_taken) begin
          ib_flush    = 1'b1;
          de_ex_flush = 1'b1;
          flush_cnt_d = FLUSH_VAL;
          state_d     = IC_FLUSH;
        end else if (mem_wait) begin
          de_ex_stop = 1'b1;
          state_d    = IC_MWAIT;
        end
      end
      IC_FLUSH: begin
        ib_flush    = 1'b1;
        flush_cnt_d = (flush_cnt_q != 2'd0) ? flush_cnt_q - 2'd1 : 2'd0;
        if (flush_cnt_q <= 2'd1) state_d = IC_ISSUE;
      end
      IC_MWAIT: begin
        if (mem_wait) de_ex_stop = 1'b1;
        else          state_d    = IC_ISSUE;
      end
      default: state_d = IC_ISSUE;
    endcase
    if (!rst) begin
      ib_flush    = 1'b0;
      de_ex_flush = 1'b0;
      de_ex_stop  = 1'b0;
    end
  end

endmodule

// File: tb/tb_issue_ctrl.sv
// Self-checking bench for issue_ctrl: directed scenarios plus randomized traffic,
// all compared against an instruction-level reference model.
module tb_issue_ctrl;

  localparam int ALU_LAT      = 1;
  localparam int LOAD_LAT     = 2;
  localparam int FLUSH_CYCLES = 1;
  localparam int M_RUN   = 0;
  localparam int M_FLUSH = 1;
  localparam int M_WAIT  = 2;
  localparam int FAB = 0;
  localparam int FAM = 1;

  typedef struct {
    bit       valid;
    bit       br;
    bit       mem;
    bit       load;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       use1;
    bit       use2;
    bit [4:0] rd;
    bit       we;
  } instr_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] ib_valid, ib_is_br, ib_is_mem, ib_is_load, ib_rs1_use, ib_rs2_use, ib_rd_we;
  logic [9:0] ib_rs1, ib_rs2, ib_rd;
  logic [1:0] ib_consume;
  logic       ib_flush, fab_issue, fab_slot, fam_issue, fam_slot, fab_num, fam_num;
  logic       de_ex_stop, de_ex_flush, br_taken, mem_wait;

  always #5 clk = ~clk;

  issue_ctrl #(.ALU_LAT(ALU_LAT), .LOAD_LAT(LOAD_LAT), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst(rst),
    .ib_valid(ib_valid), .ib_is_br(ib_is_br), .ib_is_mem(ib_is_mem), .ib_is_load(ib_is_load),
    .ib_rs1(ib_rs1), .ib_rs2(ib_rs2), .ib_rs1_use(ib_rs1_use), .ib_rs2_use(ib_rs2_use),
    .ib_rd(ib_rd), .ib_rd_we(ib_rd_we), .ib_consume(ib_consume), .ib_flush(ib_flush),
    .fab_issue(fab_issue), .fab_slot(fab_slot), .fam_issue(fam_issue), .fam_slot(fam_slot),
    .fab_num(fab_num), .fam_num(fam_num), .de_ex_stop(de_ex_stop), .de_ex_flush(de_ex_flush),
    .br_taken(br_taken), .mem_wait(mem_wait)
  );

  int checks = 0;
  int failures = 0;

  int     pend [32];
  int     mode, flushLeft;
  instr_t cur0, cur1;
  bit     curBr, curMw, go0, go1;
  logic [1:0] eConsume, lastConsume;
  logic eFabIssue, eFabSlot, eFamIssue, eFamSlot, eIbFlush, eDeFlush, eStop;
  logic lastFabIssue, lastFabSlot, lastFamIssue, lastFamSlot, lastStop, lastIbFlush, lastDeFlush;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic instr_t mkNop();
    instr_t i = '{default: 0};
    return i;
  endfunction

  function automatic instr_t mkAlu(input int rd, input int a, input int b);
    instr_t i = '{default: 0};
    i.valid = 1; i.rd = 5'(rd); i.rs1 = 5'(a); i.rs2 = 5'(b);
    i.use1 = 1; i.use2 = 1; i.we = 1;
    return i;
  endfunction

  function automatic instr_t mkLoad(input int rd, input int a);
    instr_t i = '{default: 0};
    i.valid = 1; i.mem = 1; i.load = 1; i.rd = 5'(rd); i.rs1 = 5'(a); i.use1 = 1; i.we = 1;
    return i;
  endfunction

  function automatic instr_t mkBr(input int a, input int b);
    instr_t i = '{default: 0};
    i.valid = 1; i.br = 1; i.rs1 = 5'(a); i.rs2 = 5'(b); i.use1 = 1; i.use2 = 1;
    return i;
  endfunction

  function automatic instr_t randInstr();
    instr_t i = '{default: 0};
    int kind = int'($urandom_range(0, 3));
    i.valid = ($urandom_range(0, 9) != 0);
    i.rs1 = 5'($urandom_range(0, 7));
    i.rs2 = 5'($urandom_range(0, 7));
    i.rd = 5'($urandom_range(0, 7));
    i.use1 = 1'($urandom_range(0, 1));
    i.use2 = 1'($urandom_range(0, 1));
    i.we = 1'($urandom_range(0, 1));
    case (kind)
      1: i.br = 1;
      2: begin i.mem = 1; i.load = 1; i.we = 1; end
      3: begin i.mem = 1; i.we = 0; end
      default: ;
    endcase
    return i;
  endfunction

  function automatic bit blockedBySb(input instr_t i);
    return (i.use1 && pend[i.rs1] != 0) || (i.use2 && pend[i.rs2] != 0);
  endfunction

  function automatic bit readsReg(input instr_t i, input bit [4:0] r);
    return (i.use1 && i.rs1 == r) || (i.use2 && i.rs2 == r);
  endfunction

  // Unit choice from the instruction's own class and its partner's class.
  function automatic int unitOf(input instr_t me, input bit paired, input instr_t other, input int slot);
    if (me.br) return FAB;
    if (me.mem) return FAM;
    if (!paired) return FAB;
    if (other.br) return FAM;
    if (other.mem) return FAB;
    return (slot == 0) ? FAB : FAM;
  endfunction

  task automatic applyStimulus(input instr_t s0, input instr_t s1, input bit br, input bit mw);
    cur0 = s0; cur1 = s1; curBr = br; curMw = mw;
    ib_valid = {s1.valid, s0.valid};
    ib_is_br = {s1.br, s0.br};
    ib_is_mem = {s1.mem, s0.mem};
    ib_is_load = {s1.load, s0.load};
    ib_rs1 = {s1.rs1, s0.rs1};
    ib_rs2 = {s1.rs2, s0.rs2};
    ib_rs1_use = {s1.use1, s0.use1};
    ib_rs2_use = {s1.use2, s0.use2};
    ib_rd = {s1.rd, s0.rd};
    ib_rd_we = {s1.we, s0.we};
    br_taken = br;
    mem_wait = mw;
  endtask

  task automatic markUnit(input int u, input int slot);
    if (u == FAB) begin eFabIssue = 1; eFabSlot = 1'(slot); end
    else begin eFamIssue = 1; eFamSlot = 1'(slot); end
  endtask

  task automatic computeExpected();
    bit canIssue;
    eIbFlush = 0; eDeFlush = 0; eStop = 0;
    eFabIssue = 0; eFabSlot = 0; eFamIssue = 0; eFamSlot = 0;
    if (mode == M_FLUSH) eIbFlush = 1;
    else if (mode == M_RUN && curBr) begin eIbFlush = 1; eDeFlush = 1; end
    else if (curMw) eStop = 1;
    canIssue = !curMw && (mode == M_WAIT || (mode == M_RUN && !curBr));
    go0 = canIssue && cur0.valid && !blockedBySb(cur0);
    go1 = go0 && cur1.valid && !cur0.br && !(cur0.mem && cur1.mem) && !(cur0.br && cur1.br) &&
          !(cur0.we && cur0.rd != 0 && readsReg(cur1, cur0.rd)) &&
          !(cur0.we && cur1.we && cur0.rd == cur1.rd) && !blockedBySb(cur1);
    eConsume = 2'(int'(go0) + int'(go1));
    if (go0) markUnit(unitOf(cur0, go1, cur1, 0), 0);
    if (go1) markUnit(unitOf(cur1, 1'b1, cur0, 1), 1);
  endtask

  task automatic updateModel();
    if (!curMw) for (int r = 0; r < 32; r++) if (pend[r] > 0) pend[r]--;
    if (go0 && cur0.we && cur0.rd != 0) pend[cur0.rd] = cur0.load ? LOAD_LAT : ALU_LAT;
    if (go1 && cur1.we && cur1.rd != 0) pend[cur1.rd] = cur1.load ? LOAD_LAT : ALU_LAT;
    if (mode == M_FLUSH) begin
      flushLeft--;
      if (flushLeft <= 0) mode = M_RUN;
    end else if (mode == M_RUN && curBr) begin
      mode = M_FLUSH; flushLeft = FLUSH_CYCLES;
    end else if (curMw) mode = M_WAIT;
    else mode = M_RUN;
  endtask

  task automatic resetModel();
    for (int r = 0; r < 32; r++) pend[r] = 0;
    mode = M_RUN; flushLeft = 0;
  endtask

  task automatic stepCycle();
    @(negedge clk);
    computeExpected();
    lastConsume = ib_consume; lastFabIssue = fab_issue; lastFabSlot = fab_slot;
    lastFamIssue = fam_issue; lastFamSlot = fam_slot; lastStop = de_ex_stop;
    lastIbFlush = ib_flush; lastDeFlush = de_ex_flush;
    checkOutput("consume", ib_consume, eConsume);
    checkOutput("fab_issue", fab_issue, eFabIssue);
    checkOutput("fab_slot", fab_slot, eFabSlot);
    checkOutput("fab_num", fab_num, eFabSlot);
    checkOutput("fam_issue", fam_issue, eFamIssue);
    checkOutput("fam_slot", fam_slot, eFamSlot);
    checkOutput("fam_num", fam_num, eFamSlot);
    checkOutput("ib_flush", ib_flush, eIbFlush);
    checkOutput("de_ex_flush", de_ex_flush, eDeFlush);
    checkOutput("de_ex_stop", de_ex_stop, eStop);
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_consume"}, ib_consume, 0);
    checkOutput({tag, "_fab"}, fab_issue, 0);
    checkOutput({tag, "_fam"}, fam_issue, 0);
    checkOutput({tag, "_ibflush"}, ib_flush, 0);
    checkOutput({tag, "_deflush"}, de_ex_flush, 0);
    checkOutput({tag, "_stop"}, de_ex_stop, 0);
  endtask

  initial begin
    rst = 1'b0;
    resetModel();
    applyStimulus(mkAlu(1, 2, 3), mkAlu(4, 5, 6), 1'b0, 1'b0);
    #3;
    checkAllZero("reset");
    applyStimulus(mkNop(), mkNop(), 1'b0, 1'b0);
    #9 rst = 1'b1;
    @(posedge clk); #1;

    // Independent ALU pair
    applyStimulus(mkAlu(1, 2, 3), mkAlu(4, 5, 6), 1'b0, 1'b0);
    stepCycle();
    checkOutput("pair_consume", lastConsume, 2);
    checkOutput("pair_fab_slot", lastFabSlot, 0);
    checkOutput("pair_fam_slot", lastFamSlot, 1);

    // Intra-pair RAW on x5
    applyStimulus(mkAlu(5, 2, 3), mkAlu(8, 5, 6), 1'b0, 1'b0);
    stepCycle();
    checkOutput("raw_consume", lastConsume, 1);
    applyStimulus(mkAlu(8, 5, 6), mkNop(), 1'b0, 1'b0);
    stepCycle();
    checkOutput("raw_wait", lastConsume, 0);
    stepCycle();
    checkOutput("raw_issue", lastConsume, 1);
    checkOutput("raw_fab", lastFabIssue, 1);

    // Load-use stall of two cycles
    applyStimulus(mkLoad(7, 2), mkNop(), 1'b0, 1'b0);
    stepCycle();
    checkOutput("load_fam", lastFamIssue, 1);
    applyStimulus(mkAlu(9, 7, 3), mkNop(), 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      stepCycle();
      checkOutput("load_stall", lastConsume, 0);
    end
    stepCycle();
    checkOutput("load_use_issue", lastConsume, 1);

    // Branch then taken redirect
    applyStimulus(mkBr(2, 3), mkAlu(10, 2, 3), 1'b0, 1'b0);
    stepCycle();
    checkOutput("br_consume", lastConsume, 1);
    checkOutput("br_fab", lastFabIssue, 1);
    applyStimulus(mkAlu(11, 2, 3), mkNop(), 1'b1, 1'b0);
    stepCycle();
    checkOutput("redir_deflush", lastDeFlush, 1);
    checkOutput("redir_ibflush", lastIbFlush, 1);
    applyStimulus(mkAlu(11, 2, 3), mkNop(), 1'b0, 1'b0);
    stepCycle();
    checkOutput("flush_ibflush", lastIbFlush, 1);
    checkOutput("flush_consume", lastConsume, 0);
    stepCycle();
    checkOutput("after_flush", lastConsume, 1);

    // Memory wait after a load
    applyStimulus(mkLoad(12, 2), mkNop(), 1'b0, 1'b0);
    stepCycle();
    applyStimulus(mkAlu(13, 2, 3), mkNop(), 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      stepCycle();
      checkOutput("mwait_stop", lastStop, 1);
    end
    applyStimulus(mkAlu(13, 2, 3), mkNop(), 1'b0, 1'b0);
    stepCycle();
    checkOutput("mwait_release", lastConsume, 1);
    applyStimulus(mkAlu(14, 12, 3), mkNop(), 1'b0, 1'b0);
    stepCycle();
    checkOutput("mwait_frozen", lastConsume, 0);
    stepCycle();
    checkOutput("mwait_reader", lastConsume, 1);

    // Asynchronous reset while flushing
    applyStimulus(mkAlu(15, 2, 3), mkNop(), 1'b1, 1'b0);
    stepCycle();
    applyStimulus(mkAlu(1, 2, 3), mkAlu(4, 5, 6), 1'b0, 1'b0);
    #1;
    checkOutput("in_flush", ib_flush, 1);
    #1 rst = 1'b0;
    #1;
    checkAllZero("async_reset");
    resetModel();
    @(posedge clk); #1;
    rst = 1'b1;
    stepCycle();
    checkOutput("post_reset_consume", lastConsume, 2);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus(randInstr(), randInstr(), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
      stepCycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
